// File: rtl/mem_bus_ctrl_if.sv
// Data-side bus between the core, the bus controller and the data memory.
// The master modport is the environment (core plus data memory); the controller takes the slave modport.
interface mem_bus_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Stall;
  logic [DATA_WIDTH-1:0] ID_Address;
  logic [DATA_WIDTH-1:0] ID_WriteData;
  logic                  ID_MemWrite;
  logic [DATA_WIDTH-1:0] ID_ReadData;

  modport master (
    output Address, WriteData, MemWrite, MemRead, ID_ReadData,
    input  ReadData, Stall, ID_Address, ID_WriteData, ID_MemWrite
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead, ID_ReadData,
    output ReadData, Stall, ID_Address, ID_WriteData, ID_MemWrite
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Core data-port controller: decodes data memory and GPIO regions and inserts memory wait states.
// GPIO output register, input synchroniser and sticky rising-edge flags live here.
module mem_bus_ctrl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    GPIO_WIDTH     = 8,
  parameter int                    WAIT_STATES    = 0,
  parameter logic [DATA_WIDTH-1:0] GPIO_OUT_ADDR  = DATA_WIDTH'(32'h10010024),
  parameter logic [DATA_WIDTH-1:0] GPIO_IN_ADDR   = DATA_WIDTH'(32'h10010028),
  parameter logic [DATA_WIDTH-1:0] GPIO_EDGE_ADDR = DATA_WIDTH'(32'h1001002C)
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_bus_ctrl_if.slave         bus,
  input  logic [GPIO_WIDTH-1:0] GPIO_In,
  output logic [GPIO_WIDTH-1:0] GPIO_Out
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state;
  state_t                nextState;
  logic [3:0]            cnt;
  logic [3:0]            nextCnt;
  logic                  stallInt;
  logic                  memWriteInt;

  logic                  gpioOutSel;
  logic                  gpioInSel;
  logic                  gpioEdgeSel;
  logic                  gpioSel;
  logic                  dmSel;
  logic                  req;
  logic                  dmReq;

  logic [GPIO_WIDTH-1:0] sync1;
  logic [GPIO_WIDTH-1:0] sync2;
  logic [GPIO_WIDTH-1:0] prevSample;
  logic [GPIO_WIDTH-1:0] edgeFlags;
  logic [GPIO_WIDTH-1:0] edgeClr;
  logic [GPIO_WIDTH-1:0] gpioRead;

  // Anything that is not one of the three GPIO registers goes to data memory.
  assign gpioOutSel  = (bus.Address == GPIO_OUT_ADDR);
  assign gpioInSel   = (bus.Address == GPIO_IN_ADDR);
  assign gpioEdgeSel = (bus.Address == GPIO_EDGE_ADDR);
  assign gpioSel     = gpioOutSel | gpioInSel | gpioEdgeSel;
  assign dmSel       = ~gpioSel;
  assign req         = bus.MemRead | bus.MemWrite;
  assign dmReq       = dmSel & req;

  assign bus.ID_Address   = dmSel ? bus.Address : '0;
  assign bus.ID_WriteData = bus.WriteData;
  assign edgeClr          = (bus.MemWrite && gpioEdgeSel) ? bus.WriteData[GPIO_WIDTH-1:0] : '0;

  always_comb begin
    gpioRead     = '0;
    bus.ReadData = '0;
    if (gpioOutSel)
      gpioRead = GPIO_Out;
    else if (gpioInSel)
      gpioRead = sync2;
    else if (gpioEdgeSel)
      gpioRead = edgeFlags;
    if (dmSel)
      bus.ReadData = bus.ID_ReadData;
    else
      bus.ReadData[GPIO_WIDTH-1:0] = gpioRead;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // The first stall cycle is spent in IDLE, so WAIT counts down from WAIT_STATES-1 to the completion cycle.
  always_comb begin
    nextState   = state;
    nextCnt     = cnt;
    stallInt    = 1'b0;
    memWriteInt = 1'b0;
    case (state)
      IDLE: begin
        if (dmReq) begin
          if (HAS_WAIT) begin
            stallInt  = 1'b1;
            nextCnt   = CNT_INIT;
            nextState = WAIT;
          end else begin
            memWriteInt = bus.MemWrite;
          end
        end
      end
      WAIT: begin
        if (!dmReq) begin
          nextState = IDLE;
        end else if (cnt != 4'd0) begin
          stallInt = 1'b1;
          nextCnt  = cnt - 4'd1;
        end else begin
          memWriteInt = bus.MemWrite;
          nextState   = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Reset masks the strobes so an access caught by reset never reaches memory.
  assign bus.Stall       = stallInt & reset;
  assign bus.ID_MemWrite = memWriteInt & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      GPIO_Out <= '0;
    else if (bus.MemWrite && gpioOutSel && (state == IDLE))
      GPIO_Out <= bus.WriteData[GPIO_WIDTH-1:0];
  end

  // A rising edge seen in the same cycle as its clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      prevSample <= '0;
      edgeFlags  <= '0;
    end else begin
      sync1      <= GPIO_In;
      sync2      <= sync1;
      prevSample <= sync2;
      edgeFlags  <= (edgeFlags & ~edgeClr) | (sync2 & ~prevSample);
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: one instance with no wait states, one with three.
// Stimulus queues the expected completion; per-instance monitors pop and compare when an access completes.
module tb_mem_bus_ctrl;

  localparam int          DW          = 32;
  localparam int          GW          = 8;
  localparam logic [31:0] GPIO_OUT_A  = 32'h10010024;
  localparam logic [31:0] GPIO_IN_A   = 32'h10010028;
  localparam logic [31:0] GPIO_EDGE_A = 32'h1001002C;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    bit          checkRd;
    int          stalls;
    int          pulses;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [GW-1:0] gpioIn = '0;
  logic [GW-1:0] gpioOut0;
  logic [GW-1:0] gpioOut3;

  logic [31:0]   mem0 [16];
  logic [31:0]   mem3 [16];
  logic [15:0]   written0 = '0;
  logic [15:0]   written3 = '0;

  exp_t          q0[$];
  exp_t          q3[$];
  int            testsRun = 0;
  int            testsFailed = 0;
  int            stalls0 = 0;
  int            pulses0 = 0;
  int            stalls3 = 0;
  int            pulses3 = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.DATA_WIDTH(DW)) bus0 ();
  mem_bus_ctrl_if #(.DATA_WIDTH(DW)) bus3 ();

  mem_bus_ctrl #(.DATA_WIDTH(DW), .GPIO_WIDTH(GW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .GPIO_In(gpioIn), .GPIO_Out(gpioOut0)
  );

  mem_bus_ctrl #(.DATA_WIDTH(DW), .GPIO_WIDTH(GW), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave), .GPIO_In(gpioIn), .GPIO_Out(gpioOut3)
  );

  // Data memory model: unwritten words read as 0x123456_0<index>.
  assign bus0.ID_ReadData = written0[bus0.ID_Address[5:2]] ? mem0[bus0.ID_Address[5:2]]
                                                           : (32'h12345600 | 32'(bus0.ID_Address[5:2]));
  assign bus3.ID_ReadData = written3[bus3.ID_Address[5:2]] ? mem3[bus3.ID_Address[5:2]]
                                                           : (32'h12345600 | 32'(bus3.ID_Address[5:2]));

  always @(posedge clk) begin
    if (bus0.ID_MemWrite) begin
      mem0[bus0.ID_Address[5:2]]     <= bus0.ID_WriteData;
      written0[bus0.ID_Address[5:2]] <= 1'b1;
    end
    if (bus3.ID_MemWrite) begin
      mem3[bus3.ID_Address[5:2]]     <= bus3.ID_WriteData;
      written3[bus3.ID_Address[5:2]] <= 1'b1;
    end
  end

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void scoreboard(input int inst, input logic [31:0] rd, input int st, input int pl);
    exp_t e;
    if ((inst == 0 && q0.size() == 0) || (inst != 0 && q3.size() == 0)) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL unexpected completion on dut%0d: got a completed access, expected none", inst);
      return;
    end
    if (inst == 0) e = q0.pop_front();
    else           e = q3.pop_front();
    checkOutput({e.name, " stall cycles"}, st, e.stalls);
    checkOutput({e.name, " ID_MemWrite pulses"}, pl, e.pulses);
    if (e.checkRd) checkOutput({e.name, " ReadData"}, rd, e.rdata);
  endfunction

  // Monitors: an access completes on the first requesting cycle with Stall low.
  always @(negedge clk) begin
    if (!reset) begin
      stalls0 = 0;
      pulses0 = 0;
    end else if (bus0.MemRead || bus0.MemWrite) begin
      if (bus0.ID_MemWrite) pulses0++;
      if (bus0.Stall) stalls0++;
      else begin
        scoreboard(0, bus0.ReadData, stalls0, pulses0);
        stalls0 = 0;
        pulses0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      stalls3 = 0;
      pulses3 = 0;
    end else if (bus3.MemRead || bus3.MemWrite) begin
      if (bus3.ID_MemWrite) pulses3++;
      if (bus3.Stall) stalls3++;
      else begin
        scoreboard(3, bus3.ReadData, stalls3, pulses3);
        stalls3 = 0;
        pulses3 = 0;
      end
    end
  end

  task automatic drive(input int inst, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) begin
      bus0.MemRead = rd; bus0.MemWrite = wr; bus0.Address = a; bus0.WriteData = d;
    end else begin
      bus3.MemRead = rd; bus3.MemWrite = wr; bus3.Address = a; bus3.WriteData = d;
    end
  endtask

  // Issues one access, holds it until Stall drops, returns just after the completing edge.
  task automatic applyStimulus(input int inst, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                               input string name, input logic [31:0] expRd, input int stalls, input int pulses);
    exp_t e;
    bit   done;
    bit   stallNow;
    e.name = name; e.rdata = expRd; e.checkRd = !wr; e.stalls = stalls; e.pulses = pulses;
    if (inst == 0) q0.push_back(e);
    else           q3.push_back(e);
    drive(inst, !wr, wr, addr, data);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      stallNow = (inst == 0) ? bus0.Stall : bus3.Stall;
      if (!stallNow) done = 1'b1;
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: Stall still 1 after 20 cycles, expected 0", name);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at 100000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    drive(0, 1'b0, 1'b1, 32'h10010000, 32'h11111111);
    drive(3, 1'b1, 1'b0, 32'h10010004, 32'h0);
    #2;
    checkOutput("reset Stall", bus3.Stall, 32'h0);
    checkOutput("reset ID_MemWrite", bus0.ID_MemWrite, 32'h0);
    checkOutput("reset GPIO_Out", gpioOut3, 32'h0);
    checkOutput("reset dm ReadData", bus3.ReadData, 32'h12345601);
    checkOutput("reset ID_Address", bus3.ID_Address, 32'h10010004);
    drive(3, 1'b1, 1'b0, GPIO_EDGE_A, 32'h0);
    #1;
    checkOutput("reset edge flags", bus3.ReadData, 32'h0);
    checkOutput("gpio ID_Address zero", bus3.ID_Address, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 1'b1, 32'h10010000, 32'hDEADBEEF, "ws0 write", 32'h0, 0, 1);
    applyStimulus(0, 1'b0, 32'h10010000, 32'h0, "ws0 readback", 32'hDEADBEEF, 0, 0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);

    applyStimulus(3, 1'b0, 32'h10010004, 32'h0, "ws3 read", 32'h12345601, 3, 0);
    applyStimulus(3, 1'b1, 32'h10010008, 32'h0BADF00D, "ws3 write", 32'h0, 3, 1);
    applyStimulus(3, 1'b0, 32'h10010008, 32'h0, "ws3 back-to-back read", 32'h0BADF00D, 3, 0);
    applyStimulus(3, 1'b1, GPIO_OUT_A, 32'h123456A5, "gpio out write", 32'h0, 0, 0);
    checkOutput("GPIO_Out after write", gpioOut3, 32'hA5);
    applyStimulus(3, 1'b0, GPIO_OUT_A, 32'h0, "gpio out read", 32'hA5, 0, 0);

    gpioIn = 8'h03;
    applyStimulus(3, 1'b0, GPIO_IN_A, 32'h0, "sync in +0", 32'h00, 0, 0);
    applyStimulus(3, 1'b0, GPIO_EDGE_A, 32'h0, "edge +1", 32'h00, 0, 0);
    applyStimulus(3, 1'b0, GPIO_IN_A, 32'h0, "sync in +2", 32'h03, 0, 0);
    applyStimulus(3, 1'b0, GPIO_EDGE_A, 32'h0, "edge +3", 32'h03, 0, 0);
    applyStimulus(3, 1'b1, GPIO_EDGE_A, 32'h01, "edge clear bit0", 32'h0, 0, 0);
    applyStimulus(3, 1'b0, GPIO_EDGE_A, 32'h0, "edge after clear", 32'h02, 0, 0);

    gpioIn = 8'h02;
    applyStimulus(3, 1'b0, GPIO_IN_A, 32'h0, "fall +0", 32'h03, 0, 0);
    applyStimulus(3, 1'b0, GPIO_IN_A, 32'h0, "fall +1", 32'h03, 0, 0);
    applyStimulus(3, 1'b0, GPIO_IN_A, 32'h0, "fall +2", 32'h02, 0, 0);
    gpioIn = 8'h03;
    applyStimulus(3, 1'b0, GPIO_IN_A, 32'h0, "rise +0", 32'h02, 0, 0);
    applyStimulus(3, 1'b0, GPIO_IN_A, 32'h0, "rise +1", 32'h02, 0, 0);
    applyStimulus(3, 1'b1, GPIO_EDGE_A, 32'h01, "clear with new edge", 32'h0, 0, 0);
    applyStimulus(3, 1'b0, GPIO_EDGE_A, 32'h0, "edge wins over clear", 32'h03, 0, 0);
    applyStimulus(3, 1'b1, GPIO_EDGE_A, 32'h03, "edge clear all", 32'h0, 0, 0);
    applyStimulus(3, 1'b0, GPIO_EDGE_A, 32'h0, "edge all cleared", 32'h00, 0, 0);
    applyStimulus(3, 1'b1, GPIO_IN_A, 32'hFFFFFFFF, "write to input ignored", 32'h0, 0, 0);
    applyStimulus(3, 1'b0, GPIO_IN_A, 32'h0, "input after write", 32'h03, 0, 0);
    applyStimulus(3, 1'b0, GPIO_OUT_A, 32'h0, "gpio out unchanged", 32'hA5, 0, 0);

    drive(3, 1'b0, 1'b1, 32'h1001000C, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("abort Stall", bus3.Stall, 32'h0);
    checkOutput("abort ID_MemWrite", bus3.ID_MemWrite, 32'h0);
    checkOutput("abort GPIO_Out", gpioOut3, 32'h0);
    drive(3, 1'b1, 1'b0, GPIO_EDGE_A, 32'h0);
    #1;
    checkOutput("abort edge flags", bus3.ReadData, 32'h0);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(3, 1'b0, 32'h1001000C, 32'h0, "post-reset read, no write landed", 32'h12345603, 3, 0);
    drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;

    checkOutput("dut0 scoreboard drained", q0.size(), 32'h0);
    checkOutput("dut3 scoreboard drained", q3.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
